// File: rtl/cmp_pkg.sv
// Shared compare codes, state encoding and code helper
// used by the digit comparator and the sequential accumulator.
package cmp_pkg;

    localparam logic [2:0] CMP_EQ = 3'b001;
    localparam logic [2:0] CMP_GT = 3'b010;
    localparam logic [2:0] CMP_LT = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_onehot3(input logic [2:0] c);
        return (c == CMP_EQ) || (c == CMP_GT) || (c == CMP_LT);
    endfunction

endpackage

// File: rtl/cmp_digit_seq.sv
// Sequential magnitude-compare accumulator: folds MSB-first digit codes
// into a final one-hot result plus first-differing-digit index.
// Ports: clk, rst (sync, active-high), start,
//        in_valid/in_ready/cmp_in (digit stream),
//        res_valid/res_ready/res/diff_idx/err (result), busy.
module cmp_digit_seq
    import cmp_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              cmp_in,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [2:0]              res,
    output logic [$clog2(NDIG)-1:0] diff_idx,
    output logic                    err,
    output logic                    busy
);

    localparam int CW = $clog2(NDIG);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    state_t state;
    state_t state_n;

    logic [CW-1:0] cnt;
    logic          decided;
    logic [2:0]    res_r;
    logic [CW-1:0] idx_r;
    logic          err_r;

    logic acc;
    logic last;

    // in_ready depends on state only, so acceptance never
    // loops back through in_valid.
    assign acc  = in_valid && (state == ACC);
    assign last = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = ACC;
                end
            end
            ACC: begin
                in_ready = 1'b1;
                if (acc && last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                // a start seen here is dropped on purpose
                if (res_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            decided <= 1'b0;
            res_r   <= CMP_EQ;
            idx_r   <= '0;
            err_r   <= 1'b0;
        end else if (state == IDLE && start) begin
            cnt     <= '0;
            decided <= 1'b0;
            res_r   <= CMP_EQ;
            idx_r   <= '0;
            err_r   <= 1'b0;
        end else if (acc) begin
            cnt <= last ? '0 : cnt + CW'(1);
            // malformed codes flag an error and count as eq;
            // digits after the decision are consumed unchanged
            if (!is_onehot3(cmp_in)) begin
                err_r <= 1'b1;
            end else if (!decided && cmp_in != CMP_EQ) begin
                res_r   <= cmp_in;
                idx_r   <= cnt;
                decided <= 1'b1;
            end
        end
    end

    assign res      = res_r;
    assign diff_idx = idx_r;
    assign err      = err_r;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_cmp_digit_seq.sv
// Self-checking bench for cmp_digit_seq: directed vector table,
// reset abandonment sequence and randomized streams vs a reference model.
module tb_cmp_digit_seq;
    import cmp_pkg::*;

    localparam int NDIG = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] cmp_in;
    logic       res_valid;
    logic       res_ready;
    logic [2:0] res;
    logic [1:0] diff_idx;
    logic       err;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    cmp_digit_seq #(.NDIG(NDIG)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .cmp_in   (cmp_in),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res      (res),
        .diff_idx (diff_idx),
        .err      (err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3*NDIG-1:0] codes;
        int                stall_at;
        int                stall_len;
        int                hold;
        bit                poke;
        logic [2:0]        eres;
        logic [1:0]        eidx;
        logic              eerr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // digit 0 (MSB) sits in the low bits
    function automatic logic [3*NDIG-1:0] pack4(input logic [2:0] d0,
        input logic [2:0] d1, input logic [2:0] d2, input logic [2:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    // result = first well-formed non-eq code; malformed codes only set err
    task automatic model(input logic [3*NDIG-1:0] codes,
                         output logic [2:0] r, output logic [1:0] ix,
                         output logic e);
        logic [2:0] c;
        bit found;
        r = CMP_EQ;
        ix = 2'd0;
        e = 1'b0;
        found = 0;
        for (int i = 0; i < NDIG; i++) begin
            c = codes[3*i +: 3];
            if ($countones(c) != 1) begin
                e = 1'b1;
            end else if (c != CMP_EQ && !found) begin
                found = 1;
                r = c;
                ix = 2'(i);
            end
        end
    endtask

    task automatic chk_res(input string tag, input logic [2:0] eres,
                           input logic [1:0] eidx, input logic eerr);
        chk({tag, ".res"}, res, eres);
        chk({tag, ".idx"}, diff_idx, eidx);
        chk({tag, ".err"}, err, eerr);
    endtask

    task automatic run(input vec_t v, input string tag);
        chk({tag, ".idle_busy"}, busy, 0);
        chk({tag, ".idle_rdy"}, in_ready, 0);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk({tag, ".acc_rdy"}, in_ready, 1);
        chk({tag, ".acc_busy"}, busy, 1);
        for (int i = 0; i < NDIG; i++) begin
            if (i == v.stall_at) begin
                for (int s = 0; s < v.stall_len; s++) begin
                    in_valid = 1'b0;
                    start = v.poke;
                    tick;
                    start = 1'b0;
                    chk({tag, ".stall_rv"}, res_valid, 0);
                    chk({tag, ".stall_rdy"}, in_ready, 1);
                end
            end
            in_valid = 1'b1;
            cmp_in = v.codes[3*i +: 3];
            tick;
            in_valid = 1'b0;
            cmp_in = 3'b000;
            chk({tag, ".rv_timing"}, res_valid, (i == NDIG - 1) ? 1 : 0);
        end
        chk_res(tag, v.eres, v.eidx, v.eerr);
        for (int h = 0; h < v.hold; h++) begin
            start = v.poke;
            tick;
            start = 1'b0;
            chk({tag, ".hold_rv"}, res_valid, 1);
            chk_res({tag, ".hold"}, v.eres, v.eidx, v.eerr);
        end
        res_ready = 1'b1;
        start = v.poke;
        tick;
        res_ready = 1'b0;
        start = 1'b0;
        chk({tag, ".ret_busy"}, busy, 0);
        chk({tag, ".ret_rv"}, res_valid, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".rdy"}, in_ready, 0);
        chk({tag, ".rv"}, res_valid, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".err"}, err, 0);
        chk({tag, ".res"}, res, CMP_EQ);
        chk({tag, ".idx"}, diff_idx, 0);
    endtask

    vec_t vecs[6];

    initial begin
        vec_t rv;
        logic [2:0] c;
        int r;

        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        cmp_in = 3'b000;
        res_ready = 1'b0;

        vecs[0] = '{pack4(CMP_EQ, CMP_EQ, CMP_GT, CMP_LT), -1, 0, 0, 0,
                    CMP_GT, 2'd2, 1'b0};
        vecs[1] = '{pack4(CMP_EQ, CMP_EQ, CMP_EQ, CMP_EQ), -1, 0, 0, 0,
                    CMP_EQ, 2'd0, 1'b0};
        vecs[2] = '{pack4(CMP_LT, CMP_GT, CMP_GT, CMP_EQ), 2, 3, 0, 1,
                    CMP_LT, 2'd0, 1'b0};
        vecs[3] = '{pack4(3'b011, CMP_EQ, CMP_GT, CMP_EQ), -1, 0, 5, 1,
                    CMP_GT, 2'd2, 1'b1};
        vecs[4] = '{pack4(CMP_EQ, CMP_GT, CMP_LT, CMP_LT), -1, 0, 0, 0,
                    CMP_GT, 2'd1, 1'b0};
        vecs[5] = '{pack4(CMP_EQ, CMP_EQ, CMP_EQ, CMP_LT), 1, 2, 2, 1,
                    CMP_LT, 2'd3, 1'b0};

        tick;
        tick;
        chk_reset_vals("reset");
        rst = 1'b0;
        tick;
        chk_reset_vals("post_reset");

        for (int i = 0; i < 6; i++) begin
            run(vecs[i], $sformatf("vec%0d", i));
        end

        // reset abandons a half-finished comparison
        start = 1'b1;
        tick;
        start = 1'b0;
        in_valid = 1'b1;
        cmp_in = 3'b111;
        tick;
        cmp_in = CMP_GT;
        tick;
        in_valid = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk_reset_vals("mid_acc_rst");
        run('{pack4(CMP_EQ, CMP_EQ, CMP_EQ, CMP_EQ), -1, 0, 1, 0,
              CMP_EQ, 2'd0, 1'b0}, "after_rst");

        // reset while a result is being presented
        start = 1'b1;
        tick;
        start = 1'b0;
        in_valid = 1'b1;
        cmp_in = CMP_LT;
        for (int i = 0; i < NDIG; i++) tick;
        in_valid = 1'b0;
        chk("done_rv", res_valid, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk_reset_vals("mid_done_rst");

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NDIG; i++) begin
                r = $urandom_range(0, 9);
                if (r < 3) c = CMP_EQ;
                else if (r < 6) c = CMP_GT;
                else if (r < 9) c = CMP_LT;
                else c = 3'($urandom_range(0, 7));
                rv.codes[3*i +: 3] = c;
            end
            rv.stall_at = $urandom_range(0, NDIG);
            rv.stall_len = $urandom_range(1, 3);
            rv.hold = $urandom_range(0, 3);
            rv.poke = 1'($urandom_range(0, 1));
            model(rv.codes, rv.eres, rv.eidx, rv.eerr);
            run(rv, $sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
